// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game controller.
//   - game_state_t : FSM state encoding (SERVE/PLAY/SCORED/GAME_OVER)
//   - DIR_*        : direction encoding, 0 = left/up, 1 = right/down
//   - SCREEN_*     : default visible screen and ball dimensions
//   - sat_inc      : 4-bit saturating increment used by the score counters
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE     = 2'd0,
        PLAY      = 2'd1,
        SCORED    = 2'd2,
        GAME_OVER = 2'd3
    } game_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_EDGE = 32;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_rise.sv
// rise_detect: registers a level once and flags its rising edge.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset (clears both edge registers)
//   level - input level, already in the clk domain
//   rise  - high for one cycle after the first edge that samples level high
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic cur;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= level;
            prev <= cur;
        end
    end

    // A level held high yields exactly one event.
    assign rise = cur & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game controller for the pong VGA design.
// Owns ball position/direction and both scores; advances the ball once per
// frame, resolves wall bounces and paddle hits, and sequences serve/score/
// game-over. All state moves on clk, qualified by the frame strobe.
// Ports:
//   clk, reset             - system clock, synchronous active-high reset
//   frame_tick             - high between frames; rising edge = one frame
//   start                  - player button (level); rising edge used
//   paddle_l_y, paddle_r_y - paddle top edges (sampled in the commit cycle)
//   ball_x, ball_y         - ball upper-left corner
//   score_l, score_r       - player scores (saturate at 15)
//   game_state             - current FSM state (pong_pkg::game_state_t)
//   game_over              - high in GAME_OVER
//   update_done            - one-cycle pulse when a PLAY frame update commits
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH        = SCREEN_W,
    parameter int HEIGHT       = SCREEN_H,
    parameter int BALL_SIZE    = BALL_EDGE,
    parameter int SPEED        = 2,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_L_X   = 16,
    parameter int PADDLE_R_X   = 616,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [8:0] paddle_l_y,
    input  logic [8:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] game_state,
    output logic       game_over,
    output logic       update_done
);

    // All geometry is compared in 11 bits so nothing wraps.
    localparam logic [9:0]  X_CENTER = 10'((WIDTH - BALL_SIZE) / 2);
    localparam logic [8:0]  Y_CENTER = 9'((HEIGHT - BALL_SIZE) / 2);
    localparam logic [10:0] Y_MAX    = 11'(HEIGHT - BALL_SIZE);
    localparam logic [10:0] SPD      = 11'(SPEED);
    localparam logic [10:0] BSZ      = 11'(BALL_SIZE);
    localparam logic [10:0] PH       = 11'(PADDLE_H);
    localparam logic [10:0] FACE_L   = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] FACE_R   = 11'(PADDLE_R_X - BALL_SIZE);
    localparam logic [10:0] X_MISS_R = 11'(WIDTH - BALL_SIZE - SPEED);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
    localparam int          CNT_W    = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    logic frame_rise;
    logic start_rise;

    rise_detect u_frame_rise (.clk(clk), .reset(reset), .level(frame_tick), .rise(frame_rise));
    rise_detect u_start_rise (.clk(clk), .reset(reset), .level(start),      .rise(start_rise));

    game_state_t      state_q,     state_n;
    logic [9:0]       x_q,         x_n;
    logic [8:0]       y_q,         y_n;
    logic             dir_x_q,     dir_x_n;
    logic             dir_y_q,     dir_y_n;
    logic             serve_dir_q, serve_dir_n;
    logic [3:0]       score_l_q,   score_l_n;
    logic [3:0]       score_r_q,   score_r_n;
    logic [CNT_W-1:0] cnt_q,       cnt_n;
    logic             done_q,      done_n;

    // Candidate next position for a PLAY frame; overlap uses the pre-update y.
    logic [10:0] x11, y11, pl11, pr11, x_step, y_step;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        ndx, ndy, hit, miss_left, miss_right, overlap_l, overlap_r;

    always_comb begin
        x11        = {1'b0, x_q};
        y11        = {2'b0, y_q};
        pl11       = {2'b0, paddle_l_y};
        pr11       = {2'b0, paddle_r_y};
        overlap_l  = (y11 + BSZ > pl11) && (y11 < pl11 + PH);
        overlap_r  = (y11 + BSZ > pr11) && (y11 < pr11 + PH);
        x_step     = x11;
        y_step     = y11;
        nx         = x_q;
        ny         = y_q;
        ndx        = dir_x_q;
        ndy        = dir_y_q;
        hit        = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;

        if (dir_y_q == DIR_DOWN) begin
            y_step = y11 + SPD;
            if (y_step >= Y_MAX) begin
                ny  = Y_MAX[8:0];
                ndy = DIR_UP;
            end else begin
                ny = y_step[8:0];
            end
        end else if (y11 <= SPD) begin
            ny  = 9'd0;
            ndy = DIR_DOWN;
        end else begin
            ny = 9'(y11 - SPD);
        end

        if (dir_x_q == DIR_LEFT) begin
            x_step    = x11 - SPD;
            hit       = (x11 >= FACE_L) && (x_step <= FACE_L) && overlap_l;
            miss_left = !hit && (x11 <= SPD);
            if (hit) begin
                nx  = FACE_L[9:0];
                ndx = DIR_RIGHT;
            end else begin
                nx = x_step[9:0];
            end
        end else begin
            x_step     = x11 + SPD;
            hit        = (x11 <= FACE_R) && (x_step >= FACE_R) && overlap_r;
            miss_right = !hit && (x11 >= X_MISS_R);
            if (hit) begin
                nx  = FACE_R[9:0];
                ndx = DIR_LEFT;
            end else begin
                nx = x_step[9:0];
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_n     = state_q;
        x_n         = x_q;
        y_n         = y_q;
        dir_x_n     = dir_x_q;
        dir_y_n     = dir_y_q;
        serve_dir_n = serve_dir_q;
        score_l_n   = score_l_q;
        score_r_n   = score_r_q;
        cnt_n       = cnt_q;
        done_n      = 1'b0;

        case (state_q)
            SERVE: begin
                x_n = X_CENTER;
                y_n = Y_CENTER;
                // A coincident frame rise is ignored: the ball first moves
                // on the following frame.
                if (start_rise) begin
                    state_n = PLAY;
                    dir_y_n = DIR_DOWN;
                    dir_x_n = serve_dir_q;
                end
            end
            PLAY: begin
                if (frame_rise) begin
                    done_n = 1'b1;
                    if (miss_left) begin
                        score_r_n   = sat_inc(score_r_q);
                        serve_dir_n = DIR_LEFT;
                        cnt_n       = '0;
                        state_n     = SCORED;
                    end else if (miss_right) begin
                        score_l_n   = sat_inc(score_l_q);
                        serve_dir_n = DIR_RIGHT;
                        cnt_n       = '0;
                        state_n     = SCORED;
                    end else begin
                        x_n     = nx;
                        y_n     = ny;
                        dir_x_n = ndx;
                        dir_y_n = ndy;
                    end
                end
            end
            SCORED: begin
                if (frame_rise) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_n = '0;
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_n = GAME_OVER;
                        end else begin
                            state_n = SERVE;
                            x_n     = X_CENTER;
                            y_n     = Y_CENTER;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                if (start_rise) begin
                    score_l_n = 4'd0;
                    score_r_n = 4'd0;
                    state_n   = SERVE;
                    x_n       = X_CENTER;
                    y_n       = Y_CENTER;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SERVE;
            x_q         <= X_CENTER;
            y_q         <= Y_CENTER;
            dir_x_q     <= DIR_RIGHT;
            dir_y_q     <= DIR_DOWN;
            serve_dir_q <= DIR_RIGHT;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            x_q         <= x_n;
            y_q         <= y_n;
            dir_x_q     <= dir_x_n;
            dir_y_q     <= dir_y_n;
            serve_dir_q <= serve_dir_n;
            score_l_q   <= score_l_n;
            score_r_q   <= score_r_n;
            cnt_q       <= cnt_n;
            done_q      <= done_n;
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign game_state  = state_q;
    assign game_over   = (state_q == GAME_OVER);
    assign update_done = done_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl.
// Ball trajectories are hand-computed from the serve point (304,224) moving
// 2 px per axis per frame.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [8:0] paddle_l_y;
    logic [8:0] paddle_r_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] game_state;
    logic       game_over;
    logic       update_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .game_over  (game_over),
        .update_done(update_done)
    );

    // Counts cycles with update_done high, sampled away from the active edge.
    always @(negedge clk) if (update_done) done_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, ".x"}, 32'(ball_x), x);
        check({tag, ".y"}, 32'(ball_y), y);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame(input int hold);
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (hold) @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame(1);
    endtask

    task automatic press_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        paddle_l_y = 9'd0; paddle_r_y = 9'd0;
        do_reset();

        // 1. reset values and hold in SERVE
        check("rst.state", 32'(game_state), 0);
        check_ball("rst", 304, 224);
        check("rst.score_l", 32'(score_l), 0);
        check("rst.score_r", 32'(score_r), 0);
        check("rst.game_over", 32'(game_over), 0);
        check("rst.update_done", 32'(update_done), 0);
        d0 = done_cnt;
        run_frames(5);
        check_ball("serve_hold", 304, 224);
        check("serve_hold.done", 32'(done_cnt - d0), 0);

        // 2. first move, bottom bounce
        press_start();
        check("start.state", 32'(game_state), 1);
        d0 = done_cnt;
        frame(1);
        check_ball("tick1", 306, 226);
        check("tick1.done_cycles", 32'(done_cnt - d0), 1);
        run_frames(111);
        check_ball("tick112", 528, 448);
        frame(1);
        check_ball("tick113", 530, 446);

        // 3. right paddle hit, top bounce, left miss
        paddle_r_y = 9'd380;
        run_frames(26);
        check_ball("tick139", 582, 394);
        frame(1);
        check_ball("tick140_hit", 584, 392);
        frame(1);
        check_ball("tick141", 582, 390);
        paddle_l_y = 9'd400;
        run_frames(195);
        check_ball("tick336_top", 192, 0);
        frame(1);
        check_ball("tick337", 190, 2);
        run_frames(94);
        check_ball("tick431", 2, 190);
        check("tick431.state", 32'(game_state), 1);
        d0 = done_cnt;
        frame(1);
        check("lmiss.state", 32'(game_state), 2);
        check("lmiss.score_r", 32'(score_r), 1);
        check("lmiss.score_l", 32'(score_l), 0);
        check_ball("lmiss_frozen", 2, 190);
        check("lmiss.done", 32'(done_cnt - d0), 1);
        run_frames(10);
        press_start();
        check("scored_ignores_start", 32'(game_state), 2);
        run_frames(49);
        check("scored59.state", 32'(game_state), 2);
        check_ball("scored59", 2, 190);
        frame(1);
        check("scored60.state", 32'(game_state), 0);
        check_ball("recenter", 304, 224);
        press_start();
        frame(1);
        check_ball("serve_left", 302, 226);

        // 4. right miss from a fresh game
        paddle_r_y = 9'd0;
        do_reset();
        check("rst2.state", 32'(game_state), 0);
        check("rst2.score_r", 32'(score_r), 0);
        press_start();
        run_frames(151);
        check_ball("tick151", 606, 370);
        frame(1);
        check("rmiss.state", 32'(game_state), 2);
        check("rmiss.score_l", 32'(score_l), 1);
        check_ball("rmiss_frozen", 606, 370);
        run_frames(60);
        check("rmiss60.state", 32'(game_state), 0);
        check_ball("rmiss_recenter", 304, 224);
        press_start();
        frame(1);
        check_ball("serve_right", 306, 226);
        run_frames(151);
        check("game2.score_l", 32'(score_l), 2);
        run_frames(60);

        // 5. play on to WIN_SCORE, then restart
        for (int g = 3; g <= 7; g++) begin
            press_start();
            run_frames(152);
            check("gameN.score_l", 32'(score_l), 32'(g));
            run_frames(60);
            check("gameN.state", 32'(game_state), (g == 7) ? 32'd3 : 32'd0);
        end
        check("over.game_over", 32'(game_over), 1);
        check("over.score_r", 32'(score_r), 0);
        check_ball("over_held", 606, 370);
        d0 = done_cnt;
        run_frames(3);
        check_ball("over_ignores_frame", 606, 370);
        check("over.done", 32'(done_cnt - d0), 0);
        check("over.score_l_held", 32'(score_l), 7);
        press_start();
        check("restart.state", 32'(game_state), 0);
        check("restart.score_l", 32'(score_l), 0);
        check("restart.game_over", 32'(game_over), 0);
        check_ball("restart", 304, 224);

        // 6. held frame level, reset mid-SCORED
        press_start();
        d0 = done_cnt;
        frame(10);
        check_ball("held_frame", 306, 226);
        check("held_frame.done", 32'(done_cnt - d0), 1);
        run_frames(151);
        check("pre_rst.state", 32'(game_state), 2);
        check("pre_rst.score_l", 32'(score_l), 1);
        run_frames(20);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.state", 32'(game_state), 0);
        check("midrst.score_l", 32'(score_l), 0);
        check("midrst.game_over", 32'(game_over), 0);
        check_ball("midrst", 304, 224);
        reset = 1'b0;
        d0 = done_cnt;
        run_frames(60);
        check("postrst.state", 32'(game_state), 0);
        check("postrst.done", 32'(done_cnt - d0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game controller for the pong VGA design: it owns the ball's position, direction and both scores. Once per video frame it advances the ball, resolves wall bounces and paddle hits, and runs the serve/score/game-over sequence. Its `ball_x`/`ball_y` outputs feed the pixel-compare logic that overlays the ball on the background image. It replaces the free-running slow-clock ball updater, so all state moves on the 100 MHz system clock, qualified by the frame strobe.

## Interface
- `WIDTH`, 640: visible screen width in pixels.
- `HEIGHT`, 480: visible screen height in pixels.
- `BALL_SIZE`, 32: ball edge length in pixels.
- `SPEED`, 2: pixels moved per axis per frame.
- `PADDLE_H`, 64: paddle height.
- `PADDLE_W`, 8: paddle width.
- `PADDLE_L_X`, 16: left paddle left edge.
- `PADDLE_R_X`, 616: right paddle left edge.
- `SERVE_FRAMES`, 60: frames the ball stays frozen after a point.
- `WIN_SCORE`, 7: score that ends the game.
- `clk` input 1: 100 MHz system clock. Sole clock; one clock domain.
- `reset` input 1: synchronous, active-high.
- `frame_tick` input 1: high between frames (screenEnd), already in `clk` domain. Rising edge = one frame.
- `start` input 1: player button, level. Rising edge is used.
- `paddle_l_y` input 9: left paddle top edge.
- `paddle_r_y` input 9: right paddle top edge.
- `ball_x` output 10: ball upper-left x.
- `ball_y` output 9: ball upper-left y.
- `score_l` output 4: left player score.
- `score_r` output 4: right player score.
- `game_state` output 2: current FSM state.
- `game_over` output 1: high in GAME_OVER.
- `update_done` output 1: one-cycle pulse when the frame update commits.

## Operation
- **FSM states:** SERVE=0, PLAY=1, SCORED=2, GAME_OVER=3.
- **SERVE:**
  - Ball is held at the center, (WIDTH-BALL_SIZE)/2, (HEIGHT-BALL_SIZE)/2 = (304,224).
  - A `start` rising edge goes to PLAY, with `dir_y` = down and `dir_x` = `serve_dir`.
- **PLAY, on each frame edge, y axis:**
  - Moving down: ny = y+SPEED. If ny ≥ HEIGHT-BALL_SIZE, then ny = HEIGHT-BALL_SIZE (448) and `dir_y` flips to up.
  - Moving up: if y ≤ SPEED, ny = 0 and `dir_y` flips to down; otherwise ny = y-SPEED.
- **PLAY, x axis, moving left:**
  - nx = x-SPEED.
  - Left face = PADDLE_L_X+PADDLE_W (24).
  - Hit: x ≥ face, nx ≤ face, and overlap (y+BALL_SIZE > paddle_l_y && y < paddle_l_y+PADDLE_H). On a hit, nx = face and `dir_x` flips to right.
  - Miss: no hit and x ≤ SPEED. Then `score_r`++, `serve_dir` = left, go to SCORED.
- **PLAY, x axis, moving right:**
  - Right face = PADDLE_R_X-BALL_SIZE (584).
  - Hit: x ≤ face, nx ≥ face, and overlap with `paddle_r_y`. On a hit, nx = face and `dir_x` flips to left.
  - Miss: no hit and x ≥ WIDTH-BALL_SIZE-SPEED (606). Then `score_l`++, `serve_dir` = right, go to SCORED.
- **PLAY rules shared by both axes:**
  - Overlap always uses the pre-update y.
  - x and y are resolved independently in the same frame, so a wall bounce and a paddle hit can coincide.
  - On a miss, the ball position is not updated for that frame.
- **SCORED:**
  - Ball frozen; a frame counter counts SERVE_FRAMES frame edges.
  - Then go to GAME_OVER if either score = WIN_SCORE, else to SERVE (ball re-centered).
- **GAME_OVER:**
  - Ball held, scores held.
  - A `start` rising edge clears both scores and goes to SERVE.
- All arithmetic is unsigned, computed in 11-bit intermediates so that nothing wraps.
- Scores saturate at 15.

## Timing
- **Edge detection:** `frame_tick` and `start` are each registered once.
  - rise = cur & ~prev.
  - Level held high produces exactly one event.
- **Frame latency:** `frame_tick` first sampled high at edge k → new outputs visible after edge k+1.
  - `update_done` is high for exactly the cycle those values first appear.
  - `update_done` fires only on PLAY frame updates, including a miss frame.
- **Start latency:** a `start` rise sampled at edge k → `game_state` changes after edge k+1.
  - In SERVE, a start rise and a frame rise in the same cycle: the state changes, but the ball does not move until the next frame edge.
- **Ignored events:**
  - `start` in PLAY or SCORED.
  - `frame_tick` in SERVE or GAME_OVER.
- **Reset values:** `reset` wins over everything, including mid-frame or mid-SCORED.
  - `game_state` = SERVE, `ball_x` = 304, `ball_y` = 224.
  - Scores = 0; `update_done`, `game_over` = 0.
  - `serve_dir` = right; frame counter = 0; edge registers = 0.
- Paddle inputs are sampled only in the commit cycle; they need no stability elsewhere.

## Structure
- **`pong_pkg`:**
  - State encodings SERVE/PLAY/SCORED/GAME_OVER.
  - Direction encoding: 0 = left/up, 1 = right/down.
  - Screen dimensions.
- **`rise_detect`:** one sub-module, instantiated twice (`frame_tick`, `start`).
- **Top level:**
  - FSM register.
  - Position/direction registers.
  - Combinational next-position/collision logic.
  - Score counters.
  - `SERVE_FRAMES` counter, sized $clog2(SERVE_FRAMES+1).

## Test plan
1. **Reset and hold:** reset → (304,224), SERVE, scores 0. 5 frame ticks without `start` → ball unmoved, no `update_done`.
2. **First move and bottom bounce:** `start` then 1 tick → (306,226), `update_done` 1 cycle. After 112 ticks → y=448 and `dir_y` up; tick 113 → y=446.
3. **Right paddle hit:** `paddle_r_y`=380; at tick 140, x=584, y=392 → hit. Tick 141 → x=582.
4. **Right miss:** `paddle_r_y`=0. x reaches 606 at tick 151; tick 152 → `score_l`=1, state SCORED, ball frozen. After 60 ticks → SERVE, ball at (304,224). `start` → ball moves right.
5. **Game end and restart:** repeat right misses to `score_l`=7 → GAME_OVER, `game_over`=1. `start` → scores 0, SERVE.
6. **Held levels and mid-game reset:** `frame_tick` held high 10 cycles → exactly one update. `reset` asserted in SCORED mid-count → SERVE, scores 0 on the next cycle.
